// File: rtl/one_wire_slave.sv
// 1-Wire responder emulating a DS18B20-class sensor: presence on reset,
// Read ROM / Skip ROM / Read Scratchpad / Convert T on an open-drain bus.
module one_wire_slave #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter logic [63:0] ROM_ID       = 64'hA2_00_00_0B_3C_5D_1E_28,
  parameter int unsigned RESET_MIN_US = 400,
  parameter int unsigned PRES_WAIT_US = 30,
  parameter int unsigned PRES_LOW_US  = 120,
  parameter int unsigned SAMPLE_US    = 30,
  parameter int unsigned TX0_LOW_US   = 30
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         onewire_io,
  input  logic [15:0] temp_data,
  output logic        convert_req,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        busy
);

  localparam int unsigned US_DIV = CLK_FREQ / 1_000_000;
  localparam int unsigned TW     = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  localparam logic [TW-1:0] L_TICK_MAX  = TW'(US_DIV - 1);
  localparam logic [9:0]    L_RESET_MIN = 10'(RESET_MIN_US);
  localparam logic [9:0]    L_PW        = 10'(PRES_WAIT_US - 1);
  localparam logic [9:0]    L_PL        = 10'(PRES_LOW_US - 1);
  localparam logic [9:0]    L_SAMPLE    = 10'(SAMPLE_US - 1);
  localparam logic [9:0]    L_TX0       = 10'(TX0_LOW_US - 1);

  typedef enum logic [2:0] {
    IDLE, PRES_WAIT, PRES_LOW, ROM_RX, ROM_TX, FUNC_RX, SCR_TX, DONE
  } state_t;

  state_t          r_state;
  logic            r_s1, r_s2, r_s3;
  logic [TW-1:0]   r_tick;
  logic [9:0]      r_low_us;
  logic [9:0]      r_us_cnt;
  logic [9:0]      r_slot_us;
  logic            r_slot_act;
  logic [6:0]      r_bit_cnt;
  logic [6:0]      r_shift;
  logic [15:0]     r_snap;
  logic [7:0]      r_crc;
  logic            r_dq_oe;
  logic            r_convert_req;
  logic [7:0]      r_cmd_byte;
  logic            r_cmd_valid;

  logic            w_fall, w_rise, w_slot_fall, w_tick, w_tick_clr;
  logic            w_rst_pulse, w_pres_go, w_rx_sample, w_tx_end;
  logic [7:0]      w_rx_byte, w_scr_byte, w_crc_next;
  logic            w_tx_bit, w_crc_fb;
  logic [6:0]      w_tx_last;

  assign onewire_io  = r_dq_oe ? 1'b0 : 1'bz;
  assign convert_req = r_convert_req;
  assign cmd_byte    = r_cmd_byte;
  assign cmd_valid   = r_cmd_valid;
  assign busy        = (r_state != IDLE) && (r_state != DONE);

  assign w_fall      = r_s3 & ~r_s2;
  assign w_rise      = ~r_s3 & r_s2;
  assign w_slot_fall = w_fall & ~r_dq_oe;
  assign w_tick      = (r_tick == L_TICK_MAX);
  assign w_rst_pulse = w_rise && (r_low_us >= L_RESET_MIN);
  assign w_pres_go   = (r_state == PRES_WAIT) && w_tick && (r_us_cnt == L_PW);
  // Restart the µs phase at every timing origin so delays are exact in µs
  assign w_tick_clr  = w_slot_fall | w_rst_pulse | w_pres_go;
  assign w_rx_sample = r_slot_act && w_tick && (r_slot_us == L_SAMPLE);
  assign w_tx_end    = r_slot_act && w_tick && (r_slot_us == L_TX0);
  assign w_rx_byte   = {r_s2, r_shift};
  assign w_crc_fb    = r_crc[0] ^ w_tx_bit;
  assign w_crc_next  = {1'b0, r_crc[7:1]} ^ (w_crc_fb ? 8'h8C : 8'h00);

  // Scratchpad byte and outgoing bit selection
  always_comb begin
    w_scr_byte = r_crc;
    case (r_bit_cnt[6:3])
      4'd0:    w_scr_byte = r_snap[7:0];
      4'd1:    w_scr_byte = r_snap[15:8];
      4'd2:    w_scr_byte = 8'h4B;
      4'd3:    w_scr_byte = 8'h46;
      4'd4:    w_scr_byte = 8'h7F;
      4'd5:    w_scr_byte = 8'hFF;
      4'd6:    w_scr_byte = 8'h0C;
      4'd7:    w_scr_byte = 8'h10;
      default: w_scr_byte = r_crc;
    endcase
    w_tx_bit  = (r_state == SCR_TX) ? w_scr_byte[r_bit_cnt[2:0]] : ROM_ID[r_bit_cnt[5:0]];
    w_tx_last = (r_state == SCR_TX) ? 7'd71 : 7'd63;
  end

  // Two-flop bus synchronizer plus edge-detect stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= onewire_io;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // 1 µs tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_tick <= '0;
    else if (w_tick_clr || w_tick) r_tick <= '0;
    else                          r_tick <= r_tick + 1'b1;
  end

  // Bus-low duration in µs, saturating, cleared on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_low_us <= '0;
    else if (w_rise)                           r_low_us <= '0;
    else if (!r_s2 && w_tick && r_low_us != '1) r_low_us <= r_low_us + 1'b1;
  end

  // Protocol FSM: presence, command receive, ROM/scratchpad transmit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_us_cnt      <= '0;
      r_slot_us     <= '0;
      r_slot_act    <= 1'b0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_snap        <= '0;
      r_crc         <= '0;
      r_dq_oe       <= 1'b0;
      r_convert_req <= 1'b0;
      r_cmd_byte    <= '0;
      r_cmd_valid   <= 1'b0;
    end else begin
      r_cmd_valid   <= 1'b0;
      r_convert_req <= 1'b0;
      if (r_slot_act && w_tick) r_slot_us <= r_slot_us + 1'b1;
      if (w_rst_pulse) begin
        r_state    <= PRES_WAIT;
        r_dq_oe    <= 1'b0;
        r_bit_cnt  <= '0;
        r_us_cnt   <= '0;
        r_slot_act <= 1'b0;
        r_crc      <= '0;
      end else begin
        case (r_state)
          PRES_WAIT: if (w_tick) begin
            if (r_us_cnt == L_PW) begin
              r_state  <= PRES_LOW;
              r_dq_oe  <= 1'b1;
              r_us_cnt <= '0;
            end else r_us_cnt <= r_us_cnt + 1'b1;
          end
          PRES_LOW: if (w_tick) begin
            if (r_us_cnt == L_PL) begin
              r_state  <= ROM_RX;
              r_dq_oe  <= 1'b0;
              r_us_cnt <= '0;
            end else r_us_cnt <= r_us_cnt + 1'b1;
          end
          ROM_RX, FUNC_RX: begin
            if (w_slot_fall) begin
              r_slot_act <= 1'b1;
              r_slot_us  <= '0;
            end else if (w_rx_sample) begin
              r_slot_act <= 1'b0;
              r_shift    <= w_rx_byte[7:1];
              if (r_bit_cnt == 7'd7) begin
                r_bit_cnt   <= '0;
                r_cmd_byte  <= w_rx_byte;
                r_cmd_valid <= 1'b1;
                if (r_state == ROM_RX) begin
                  if (w_rx_byte == 8'h33)      r_state <= ROM_TX;
                  else if (w_rx_byte == 8'hCC) r_state <= FUNC_RX;
                  else                         r_state <= DONE;
                end else begin
                  if (w_rx_byte == 8'hBE) begin
                    r_snap  <= temp_data;
                    r_crc   <= '0;
                    r_state <= SCR_TX;
                  end else begin
                    r_convert_req <= (w_rx_byte == 8'h44);
                    r_state       <= DONE;
                  end
                end
              end else r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          ROM_TX, SCR_TX: begin
            if (w_slot_fall) begin
              r_slot_act <= 1'b1;
              r_slot_us  <= '0;
              r_dq_oe    <= ~w_tx_bit;
              if (r_state == SCR_TX && r_bit_cnt < 7'd64) r_crc <= w_crc_next;
            end else if (w_tx_end) begin
              r_slot_act <= 1'b0;
              r_dq_oe    <= 1'b0;
              if (r_bit_cnt == w_tx_last) begin
                r_bit_cnt <= '0;
                r_state   <= DONE;
              end else r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_one_wire_slave.sv
// Directed bench for one_wire_slave acting as the 1-Wire bus master.
`timescale 1ns/1ps
module tb_one_wire_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_low;
  logic [15:0] temp_data;
  logic        convert_req;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic        busy;
  wire         w_bus;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cv   = 0;
  int n_cr   = 0;

  logic [7:0] exp_rom [8] = '{8'h28, 8'h1E, 8'h5D, 8'h3C, 8'h0B, 8'h00, 8'h00, 8'hA2};
  logic [7:0] exp_scr [8] = '{8'h90, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
  logic [7:0] got [9];

  assign w_bus = m_low ? 1'b0 : 1'bz;
  pullup (w_bus);

  one_wire_slave #(.CLK_FREQ(4_000_000)) dut (
    .clk         (clk),
    .rst         (rst),
    .onewire_io  (w_bus),
    .temp_data   (temp_data),
    .convert_req (convert_req),
    .cmd_byte    (cmd_byte),
    .cmd_valid   (cmd_valid),
    .busy        (busy)
  );

  always #125 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid === 1'b1)   n_cv++;
    if (convert_req === 1'b1) n_cr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_cmp++;
    assert (v >= lo && v <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic wait_us(input int us);
    #(us * 1000);
  endtask

  function automatic logic [7:0] crc8(input int n);
    logic [7:0] c = 8'h00;
    logic       fb;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ got[i][b];
        c  = (c >> 1) ^ (fb ? 8'h8C : 8'h00);
      end
    return c;
  endfunction

  // Reset pulse; returns presence delay and width in ns (-1 if absent)
  task automatic bus_reset(input int low_us, output int t_pres, output int t_width);
    time t0, tf;
    bit  seen;
    m_low = 1'b1;
    wait_us(low_us);
    m_low   = 1'b0;
    t0      = $time;
    t_pres  = -1;
    t_width = -1;
    seen    = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      #50;
      if (w_bus === 1'b0) seen = 1'b1;
    end
    if (seen) begin
      tf     = $time;
      t_pres = int'(tf - t0);
      seen   = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
        #50;
        if (w_bus === 1'b1) seen = 1'b1;
      end
      if (seen) t_width = int'($time - tf);
    end
    wait_us(10);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    wait_us(b ? 2 : 60);
    m_low = 1'b0;
    wait_us(b ? 60 : 2);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b1;
    wait_us(1);
    m_low = 1'b0;
    wait_us(12);
    b = w_bus;
    wait_us(50);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  initial begin
    int   tp, tw;
    logic b;
    rst       = 1'b1;
    m_low     = 1'b0;
    temp_data = 16'h0190;
    wait_us(2);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_convert_req", convert_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_released", w_bus, 1'b1);
    rst = 1'b0;
    wait_us(5);

    // Short low is not a reset
    bus_reset(200, tp, tw);
    chk("short_low_no_presence", tp, -1);
    chk("short_low_busy", busy, 1'b0);

    // Full reset: presence timing
    bus_reset(480, tp, tw);
    chk_rng("presence_delay_ns", tp, 29000, 31000);
    chk_rng("presence_width_ns", tw, 119000, 121000);
    chk("after_presence_busy", busy, 1'b1);

    // Skip ROM + Read Scratchpad, temp changes mid-transfer
    n_cv = 0;
    write_byte(8'hCC);
    chk("skip_cmd_byte", cmd_byte, 8'hCC);
    write_byte(8'hBE);
    chk("rdscr_cmd_byte", cmd_byte, 8'hBE);
    chk("rdscr_cmd_valid_count", n_cv, 2);
    for (int i = 0; i < 4; i++) read_byte(got[i]);
    temp_data = 16'hFE6F;
    for (int i = 4; i < 9; i++) read_byte(got[i]);
    for (int i = 0; i < 8; i++) chk($sformatf("scr_byte%0d", i), got[i], exp_scr[i]);
    chk("scr_crc_byte", got[8], crc8(8));
    chk("scr_crc_all9_zero", crc8(9), 8'h00);
    chk("scr_temp_c", $signed({got[1], got[0]}) >>> 4, 25);
    chk("scr_done_busy", busy, 1'b0);
    read_bit(b);
    chk("scr_done_read1", b, 1'b1);
    temp_data = 16'h0190;

    // Skip ROM + Convert T
    bus_reset(420, tp, tw);
    chk_rng("conv_presence_delay_ns", tp, 29000, 31000);
    n_cv = 0;
    n_cr = 0;
    write_byte(8'hCC);
    write_byte(8'h44);
    chk("conv_cmd_byte", cmd_byte, 8'h44);
    chk("conv_req_cycles", n_cr, 1);
    chk("conv_cmd_valid_count", n_cv, 2);
    chk("conv_convert_req_low", convert_req, 1'b0);
    read_bit(b);
    chk("conv_read1", b, 1'b1);
    chk("conv_busy", busy, 1'b0);

    // Abort a scratchpad read after byte 3, then Read ROM
    bus_reset(420, tp, tw);
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 4; i++) read_byte(got[i]);
    chk("abort_byte0", got[0], 8'h90);
    chk("abort_byte3", got[3], 8'h46);
    bus_reset(480, tp, tw);
    chk_rng("abort_presence_delay_ns", tp, 29000, 31000);
    chk_rng("abort_presence_width_ns", tw, 119000, 121000);
    n_cv = 0;
    write_byte(8'h33);
    chk("rom_cmd_byte", cmd_byte, 8'h33);
    chk("rom_cmd_valid_count", n_cv, 1);
    for (int i = 0; i < 8; i++) read_byte(got[i]);
    for (int i = 0; i < 8; i++) chk($sformatf("rom_byte%0d", i), got[i], exp_rom[i]);
    chk("rom_done_busy", busy, 1'b0);
    read_bit(b);
    chk("rom_done_read1", b, 1'b1);

    // Async reset while the slave drives presence
    m_low = 1'b1;
    wait_us(480);
    m_low = 1'b0;
    for (int i = 0; i < 1200 && w_bus !== 1'b0; i++) #50;
    chk("rst_mid_presence_driving", w_bus, 1'b0);
    wait_us(20);
    rst = 1'b1;
    #100;
    chk("rst_mid_presence_released", w_bus, 1'b1);
    chk("rst_mid_presence_busy", busy, 1'b0);
    wait_us(1);
    rst = 1'b0;
    wait_us(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
